// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the multi-line HD44780-style cursor controller.
// This package holds the controller state encoding, the LCD command bytes,
// the DDRAM row base addresses and a small row-base helper.
// Optional feature macro: LCD_BACKSPACE_EN adds the backspace states.
// -----------------------------------------------------------------------------
package lcd_pkg;

   // Controller states; the backspace states exist only when that feature is built
   typedef enum logic [3:0] {
      ST_DELAY    = 4'd0,
      ST_FUNC_SET = 4'd1,
      ST_DISP_ON  = 4'd2,
      ST_ENTRY    = 4'd3,
      ST_CLEAR    = 4'd4,
      ST_IDLE     = 4'd5,
      ST_WRITE    = 4'd6,
      ST_MOVE     = 4'd7
`ifdef LCD_BACKSPACE_EN
      ,
      ST_BK_MOVE  = 4'd8,
      ST_BK_WRITE = 4'd9,
      ST_BK_BACK  = 4'd10
`endif
   } lcdState_e;

   // Direction of a cursor step
   typedef enum logic {
      ADDR_INC = 1'b0,
      ADDR_DEC = 1'b1
   } addrOp_e;

   localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0F;
   localparam logic [7:0] CMD_ENTRY     = 8'h06;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
   localparam logic [7:0] CHAR_SPACE    = 8'h20;

   localparam logic [6:0] ROW_BASE0 = 7'h00;
   localparam logic [6:0] ROW_BASE1 = 7'h40;

   // At most two rows, so any non-zero row is the second line
   function automatic logic [6:0] rowBase(input logic isRow1);
      return isRow1 ? ROW_BASE1 : ROW_BASE0;
   endfunction

endpackage

// File: rtl/lcd_addr_calc.sv
// -----------------------------------------------------------------------------
// lcd_addr_calc
// Combinational cursor stepper: given the current row/column and a direction,
// produces the neighbouring cursor position (with row wrap at the line ends)
// and the DDRAM address of that position.
// Ports:
//   row_i, col_i   current cursor
//   op_i           ADDR_INC (right / after a write) or ADDR_DEC (left)
//   nextRow_o      row after the step
//   nextCol_o      column after the step
//   addr_o         DDRAM address of the stepped position
// -----------------------------------------------------------------------------
module lcd_addr_calc
   import lcd_pkg::*;
#(
   parameter int ROWS = 2,
   parameter int COLS = 16,
   parameter int RW   = 1,
   parameter int CW   = 4
) (
   input  logic [RW-1:0] row_i,
   input  logic [CW-1:0] col_i,
   input  addrOp_e       op_i,
   output logic [RW-1:0] nextRow_o,
   output logic [CW-1:0] nextCol_o,
   output logic [6:0]    addr_o
);

   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

   // Stepping past either end of a line moves to the neighbouring row, and the
   // rows themselves wrap so the cursor runs around the whole display
   always_comb begin
      nextRow_o = row_i;
      nextCol_o = col_i;
      if (op_i == ADDR_INC) begin
         if (col_i == COL_MAX) begin
            nextCol_o = '0;
            nextRow_o = (row_i == ROW_MAX) ? '0 : row_i + RW'(1);
         end else begin
            nextCol_o = col_i + CW'(1);
         end
      end else begin
         if (col_i == '0) begin
            nextCol_o = COL_MAX;
            nextRow_o = (row_i == '0) ? ROW_MAX : row_i - RW'(1);
         end else begin
            nextCol_o = col_i - CW'(1);
         end
      end
      addr_o = rowBase(nextRow_o != '0) + 7'(nextCol_o);
   end

endmodule

// File: rtl/lcd_cursor_multiline.sv
// -----------------------------------------------------------------------------
// lcd_cursor_multiline
// Character-LCD controller with a tracked multi-line cursor. After power-up it
// runs the init sequence (function set, display on, entry mode, clear), then
// accepts one-shot write / clear / left / right requests while idle.
// Every state dwells its delay plus one cycle (count runs 0..DLY), and LCD_E
// pulses once at count == STROBE in every command or write state.
// Outputs are registered from the next-state values so they line up with the
// state exactly and are glitch-free on the LCD pins.
// Ports:
//   clk, rst (async, active-low)
//   char_valid/char_code, left, right, clear   one-shot requests
//   bksp                                       one-shot backspace (LCD_BACKSPACE_EN)
//   LCD_E, LCD_RS, LCD_RW, LCD_DATA            LCD bus
//   busy                                       controller not idle
//   cur_row, cur_col                           tracked cursor
//   LED_out                                    one-hot state indicator
// Optional feature macro: LCD_BACKSPACE_EN.
// -----------------------------------------------------------------------------
module lcd_cursor_multiline
   import lcd_pkg::*;
#(
   parameter int ROWS     = 2,
   parameter int COLS     = 16,
   parameter int INIT_DLY = 70,
   parameter int CMD_DLY  = 30,
   parameter int CLR_DLY  = 100,
   parameter int STROBE   = 20,
   localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          char_valid,
   input  logic [7:0]    char_code,
   input  logic          left,
   input  logic          right,
   input  logic          clear,
`ifdef LCD_BACKSPACE_EN
   input  logic          bksp,
`endif
   output logic          LCD_E,
   output logic          LCD_RS,
   output logic          LCD_RW,
   output logic [7:0]    LCD_DATA,
   output logic          busy,
   output logic [RW-1:0] cur_row,
   output logic [CW-1:0] cur_col,
   output logic [7:0]    LED_out
);

   localparam int MAX_A = (INIT_DLY > CLR_DLY) ? INIT_DLY : CLR_DLY;
   localparam int MAX_DLY = (MAX_A > CMD_DLY) ? MAX_A : CMD_DLY;
   localparam int CNT_W = $clog2(MAX_DLY + 1);

   lcdState_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, dwell;
   logic [RW-1:0] row_q, row_d, incRow, decRow;
   logic [CW-1:0] col_q, col_d, incCol, decCol;
   logic [7:0]    char_q, char_d;
   logic [6:0]    addr_q, addr_d, incAddr, decAddr;
   logic          wrapMove_q, wrapMove_d;
   logic          done;
   logic          lcdE_q, lcdE_d, lcdRs_q, lcdRs_d, busy_q, busy_d, strobeOk;
   logic [7:0]    lcdData_q, lcdData_d, led_q, led_d;
   logic          bkspReq;

`ifdef LCD_BACKSPACE_EN
   assign bkspReq = bksp;
`else
   assign bkspReq = 1'b0;
`endif

   lcd_addr_calc #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) incCalc (
      .row_i(row_q), .col_i(col_q), .op_i(ADDR_INC),
      .nextRow_o(incRow), .nextCol_o(incCol), .addr_o(incAddr)
   );

   lcd_addr_calc #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) decCalc (
      .row_i(row_q), .col_i(col_q), .op_i(ADDR_DEC),
      .nextRow_o(decRow), .nextCol_o(decCol), .addr_o(decAddr)
   );

   // State, cursor and registered bus outputs; reset aborts any command at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_DELAY;
         cnt_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         char_q     <= '0;
         addr_q     <= '0;
         wrapMove_q <= 1'b0;
         lcdE_q     <= 1'b0;
         lcdRs_q    <= 1'b0;
         lcdData_q  <= 8'h00;
         led_q      <= 8'h00;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         row_q      <= row_d;
         col_q      <= col_d;
         char_q     <= char_d;
         addr_q     <= addr_d;
         wrapMove_q <= wrapMove_d;
         lcdE_q     <= lcdE_d;
         lcdRs_q    <= lcdRs_d;
         lcdData_q  <= lcdData_d;
         led_q      <= led_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state logic: fixed init chain, then request dispatch from IDLE.
   // The cursor moves in the accepting cycle; the LCD catches up via MOVE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      row_d      = row_q;
      col_d      = col_q;
      char_d     = char_q;
      addr_d     = addr_q;
      wrapMove_d = wrapMove_q;
      dwell      = CNT_W'(CMD_DLY);
      if (state_q == ST_DELAY) dwell = CNT_W'(INIT_DLY);
      if (state_q == ST_CLEAR) dwell = CNT_W'(CLR_DLY);
      done = (cnt_q == dwell);

      case (state_q)
         ST_DELAY:    if (done) state_d = ST_FUNC_SET;
         ST_FUNC_SET: if (done) state_d = ST_DISP_ON;
         ST_DISP_ON:  if (done) state_d = ST_ENTRY;
         ST_ENTRY:    if (done) state_d = ST_CLEAR;
         ST_CLEAR:    if (done) state_d = ST_IDLE;
         ST_IDLE: begin
            cnt_d = '0;
            if (char_valid) begin
               char_d     = char_code;
               row_d      = incRow;
               col_d      = incCol;
               addr_d     = incAddr;
               wrapMove_d = (incCol == '0);
               state_d    = ST_WRITE;
            end else if (clear) begin
               row_d   = '0;
               col_d   = '0;
               state_d = ST_CLEAR;
            end else if (bkspReq) begin
               row_d   = decRow;
               col_d   = decCol;
               addr_d  = decAddr;
`ifdef LCD_BACKSPACE_EN
               state_d = ST_BK_MOVE;
`endif
            end else if (left) begin
               row_d   = decRow;
               col_d   = decCol;
               addr_d  = decAddr;
               state_d = ST_MOVE;
            end else if (right) begin
               row_d   = incRow;
               col_d   = incCol;
               addr_d  = incAddr;
               state_d = ST_MOVE;
            end
         end
         ST_WRITE:    if (done) state_d = wrapMove_q ? ST_MOVE : ST_IDLE;
         ST_MOVE:     if (done) state_d = ST_IDLE;
`ifdef LCD_BACKSPACE_EN
         ST_BK_MOVE:  if (done) state_d = ST_BK_WRITE;
         ST_BK_WRITE: if (done) state_d = ST_BK_BACK;
         ST_BK_BACK:  if (done) state_d = ST_IDLE;
`endif
         default:     state_d = ST_DELAY;
      endcase

      if (state_d != state_q) cnt_d = '0;
   end

   // Bus word, LED pattern and strobe for the state being entered
   always_comb begin
      lcdRs_d   = 1'b0;
      lcdData_d = 8'h00;
      led_d     = 8'h00;
      strobeOk  = 1'b1;
      case (state_d)
         ST_DELAY:    begin led_d = 8'h80; strobeOk = 1'b0; end
         ST_FUNC_SET: begin led_d = 8'h40; lcdData_d = CMD_FUNC_SET; end
         ST_DISP_ON:  begin led_d = 8'h20; lcdData_d = CMD_DISP_ON; end
         ST_ENTRY:    begin led_d = 8'h10; lcdData_d = CMD_ENTRY; end
         ST_CLEAR:    begin led_d = 8'h08; lcdData_d = CMD_CLEAR; end
         ST_IDLE:     begin led_d = 8'h04; strobeOk = 1'b0; end
         ST_WRITE:    begin led_d = 8'h02; lcdRs_d = 1'b1; lcdData_d = char_d; end
         ST_MOVE:     begin led_d = 8'h01; lcdData_d = CMD_SET_DDRAM | {1'b0, addr_d}; end
`ifdef LCD_BACKSPACE_EN
         ST_BK_MOVE:  begin led_d = 8'h01; lcdData_d = CMD_SET_DDRAM | {1'b0, addr_d}; end
         ST_BK_WRITE: begin led_d = 8'h02; lcdRs_d = 1'b1; lcdData_d = CHAR_SPACE; end
         ST_BK_BACK:  begin led_d = 8'h01; lcdData_d = CMD_SET_DDRAM | {1'b0, addr_d}; end
`endif
         default:     strobeOk = 1'b0;
      endcase
      lcdE_d = strobeOk && (cnt_d == CNT_W'(STROBE));
      busy_d = (state_d != ST_IDLE);
   end

   assign LCD_E    = lcdE_q;
   assign LCD_RS   = lcdRs_q;
   assign LCD_RW   = 1'b0;
   assign LCD_DATA = lcdData_q;
   assign busy     = busy_q;
   assign cur_row  = row_q;
   assign cur_col  = col_q;
   assign LED_out  = led_q;

endmodule

// File: tb/tb_lcd_cursor_multiline.sv
// -----------------------------------------------------------------------------
// tb_lcd_cursor_multiline
// Self-checking bench for lcd_cursor_multiline (default 2x16 geometry).
// A monitor records every LCD_E strobe as {RS, DATA}; each test task drives
// requests and compares the strobe list and cursor against expected values.
// The random test uses a linear-position model of the cursor.
// Honours LCD_BACKSPACE_EN for the bksp port and its scenario.
// -----------------------------------------------------------------------------
module tb_lcd_cursor_multiline;

   localparam int ROWS = 2, COLS = 16, INIT_DLY = 70, CMD_DLY = 30, CLR_DLY = 100, STROBE = 20;
   localparam int NPOS = ROWS * COLS;
`ifdef LCD_BACKSPACE_EN
   localparam int MASK_MAX = 31;
`else
   localparam int MASK_MAX = 15;
`endif

   logic       clk = 1'b0, rst = 1'b0;
   logic       char_valid = 1'b0, left = 1'b0, right = 1'b0, clear = 1'b0;
   logic [7:0] char_code = 8'h00;
`ifdef LCD_BACKSPACE_EN
   logic       bksp = 1'b0;
`endif
   logic       LCD_E, LCD_RS, LCD_RW, busy;
   logic [7:0] LCD_DATA, LED_out;
   logic [0:0] cur_row;
   logic [3:0] cur_col;

   int checks = 0, failures = 0;
   int cyc = 0;
   int wideCount = 0;
   logic prevE = 1'b0;
   logic [8:0] stbQ[$];
   int stbCyc[$];

   lcd_cursor_multiline #(.ROWS(ROWS), .COLS(COLS), .INIT_DLY(INIT_DLY), .CMD_DLY(CMD_DLY),
                          .CLR_DLY(CLR_DLY), .STROBE(STROBE)) dut (
      .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
      .left(left), .right(right), .clear(clear),
`ifdef LCD_BACKSPACE_EN
      .bksp(bksp),
`endif
      .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA),
      .busy(busy), .cur_row(cur_row), .cur_col(cur_col), .LED_out(LED_out)
   );

   always #5 clk = ~clk;

   // Edge counter: value seen at a negedge is the index of the preceding posedge
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor, sampled half a cycle away from the active edge
   always @(negedge clk) begin
      if (LCD_E === 1'b1) begin
         stbQ.push_back({LCD_RS, LCD_DATA});
         stbCyc.push_back(cyc);
         if (prevE === 1'b1) wideCount <= wideCount + 1;
      end
      prevE <= LCD_E;
   end

   // DDRAM set-address command for a linear cursor position
   function automatic logic [7:0] mvCmd(input int p);
      int base;
      base = ((p / COLS) == 1) ? 'h40 : 0;
      return 8'h80 | 8'(base + (p % COLS));
   endfunction

   // mask bits: 0 char_valid, 1 clear, 2 left, 3 right, 4 bksp
   task automatic applyStimulus(input logic [4:0] mask, input logic [7:0] code);
      @(negedge clk);
      char_code  = code;
      char_valid = mask[0];
      clear      = mask[1];
      left       = mask[2];
      right      = mask[3];
`ifdef LCD_BACKSPACE_EN
      bksp       = mask[4];
`endif
      @(negedge clk);
      char_valid = 1'b0;
      clear      = 1'b0;
      left       = 1'b0;
      right      = 1'b0;
`ifdef LCD_BACKSPACE_EN
      bksp       = 1'b0;
`endif
   endtask

   task automatic waitIdle(input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         checks++; failures++;
         $display("[TB] FAIL idle_timeout busy=%b required=0", busy);
      end
   endtask

   task automatic test_reset();
      logic [8:0] initWords[4];
      int rel;
      initWords = '{9'h038, 9'h00F, 9'h006, 9'h001};
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (LCD_E !== 1'b0) begin failures++; $display("[TB] FAIL rst_E got=%b exp=0", LCD_E); end
      checks++; if (LCD_RS !== 1'b0) begin failures++; $display("[TB] FAIL rst_RS got=%b exp=0", LCD_RS); end
      checks++; if (LCD_RW !== 1'b0) begin failures++; $display("[TB] FAIL rst_RW got=%b exp=0", LCD_RW); end
      checks++; if (LCD_DATA !== 8'h00) begin failures++; $display("[TB] FAIL rst_DATA got=%h exp=00", LCD_DATA); end
      checks++; if (LED_out !== 8'h00) begin failures++; $display("[TB] FAIL rst_LED got=%h exp=00", LED_out); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=1", busy); end
      checks++; if (cur_row !== 1'b0 || cur_col !== 4'd0) begin
         failures++; $display("[TB] FAIL rst_cursor got=(%0d,%0d) exp=(0,0)", cur_row, cur_col); end
      stbQ.delete(); stbCyc.delete();
      rel = cyc;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (LED_out !== 8'h80) begin failures++; $display("[TB] FAIL led_delay got=%h exp=80", LED_out); end
      waitIdle(2000);
      checks++;
      if (stbQ.size() != 4) begin
         failures++; $display("[TB] FAIL init_count got=%0d exp=4", stbQ.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (stbQ[k] !== initWords[k]) begin
               failures++; $display("[TB] FAIL init_word%0d got=%h exp=%h", k, stbQ[k], initWords[k]);
            end
         end
         checks++;
         if (stbCyc[0] - rel != INIT_DLY + 1 + STROBE) begin
            failures++; $display("[TB] FAIL init_first_strobe got=%0d exp=%0d", stbCyc[0] - rel, INIT_DLY + 1 + STROBE);
         end
      end
      checks++; if (LED_out !== 8'h04) begin failures++; $display("[TB] FAIL led_idle got=%h exp=04", LED_out); end
   endtask

   task automatic test_write();
      int acc, n;
      stbQ.delete(); stbCyc.delete();
      applyStimulus(5'b00001, 8'h41);
      acc = cyc;
      checks++; if (cur_row !== 1'b0 || cur_col !== 4'd1) begin
         failures++; $display("[TB] FAIL write_cursor got=(%0d,%0d) exp=(0,1)", cur_row, cur_col); end
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n != CMD_DLY + 1) begin failures++; $display("[TB] FAIL write_busy_len got=%0d exp=%0d", n, CMD_DLY + 1); end
      checks++;
      if (stbQ.size() != 1) begin
         failures++; $display("[TB] FAIL write_strobes got=%0d exp=1", stbQ.size());
      end else begin
         checks++; if (stbQ[0] !== 9'h141) begin failures++; $display("[TB] FAIL write_word got=%h exp=141", stbQ[0]); end
         checks++; if (stbCyc[0] - acc != STROBE) begin
            failures++; $display("[TB] FAIL write_strobe_pos got=%0d exp=%0d", stbCyc[0] - acc, STROBE); end
      end
   endtask

   task automatic test_wrap();
      applyStimulus(5'b00010, 8'h00);
      waitIdle(500);
      stbQ.delete(); stbCyc.delete();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(5'b00001, 8'h61 + 8'(i));
         waitIdle(500);
      end
      checks++;
      if (stbQ.size() != 17) begin
         failures++; $display("[TB] FAIL wrap16_count got=%0d exp=17", stbQ.size());
      end else begin
         checks++; if (stbQ[15] !== 9'h170) begin failures++; $display("[TB] FAIL wrap16_char got=%h exp=170", stbQ[15]); end
         checks++; if (stbQ[16] !== 9'h0C0) begin failures++; $display("[TB] FAIL wrap16_move got=%h exp=0C0", stbQ[16]); end
      end
      checks++; if (cur_row !== 1'b1 || cur_col !== 4'd0) begin
         failures++; $display("[TB] FAIL wrap16_cursor got=(%0d,%0d) exp=(1,0)", cur_row, cur_col); end
      for (int i = 0; i < 16; i++) begin
         applyStimulus(5'b00001, 8'h41 + 8'(i));
         waitIdle(500);
      end
      checks++;
      if (stbQ.size() != 34) begin
         failures++; $display("[TB] FAIL wrap32_count got=%0d exp=34", stbQ.size());
      end else begin
         checks++; if (stbQ[33] !== 9'h080) begin failures++; $display("[TB] FAIL wrap32_move got=%h exp=080", stbQ[33]); end
      end
      checks++; if (cur_row !== 1'b0 || cur_col !== 4'd0) begin
         failures++; $display("[TB] FAIL wrap32_cursor got=(%0d,%0d) exp=(0,0)", cur_row, cur_col); end
   endtask

   task automatic test_left_right();
      stbQ.delete(); stbCyc.delete();
      applyStimulus(5'b00100, 8'h00);
      waitIdle(500);
      checks++; if (stbQ.size() != 1 || stbQ[0] !== 9'h0CF) begin
         failures++; $display("[TB] FAIL left_move got_n=%0d exp=0CF", stbQ.size()); end
      checks++; if (cur_row !== 1'b1 || cur_col !== 4'd15) begin
         failures++; $display("[TB] FAIL left_cursor got=(%0d,%0d) exp=(1,15)", cur_row, cur_col); end
      stbQ.delete(); stbCyc.delete();
      applyStimulus(5'b01000, 8'h00);
      waitIdle(500);
      checks++; if (stbQ.size() != 1 || stbQ[0] !== 9'h080) begin
         failures++; $display("[TB] FAIL right_move got_n=%0d exp=080", stbQ.size()); end
      checks++; if (cur_row !== 1'b0 || cur_col !== 4'd0) begin
         failures++; $display("[TB] FAIL right_cursor got=(%0d,%0d) exp=(0,0)", cur_row, cur_col); end
   endtask

   task automatic test_priority();
      stbQ.delete(); stbCyc.delete();
      applyStimulus(5'b00101, 8'h5A);
      checks++; if (cur_row !== 1'b0 || cur_col !== 4'd1) begin
         failures++; $display("[TB] FAIL prio_cursor got=(%0d,%0d) exp=(0,1)", cur_row, cur_col); end
      applyStimulus(5'b01000, 8'h00);
      checks++; if (cur_row !== 1'b0 || cur_col !== 4'd1) begin
         failures++; $display("[TB] FAIL busy_drop got=(%0d,%0d) exp=(0,1)", cur_row, cur_col); end
      waitIdle(500);
      checks++; if (stbQ.size() != 1 || stbQ[0] !== 9'h15A) begin
         failures++; $display("[TB] FAIL prio_strobes got_n=%0d exp=15A only", stbQ.size()); end
      checks++; if (cur_col !== 4'd1) begin
         failures++; $display("[TB] FAIL prio_final_col got=%0d exp=1", cur_col); end
   endtask

`ifdef LCD_BACKSPACE_EN
   task automatic test_bksp();
      logic [8:0] exp3[3];
      exp3 = '{9'h084, 9'h120, 9'h084};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(5'b01000, 8'h00);
         waitIdle(500);
      end
      stbQ.delete(); stbCyc.delete();
      applyStimulus(5'b10000, 8'h00);
      waitIdle(500);
      checks++;
      if (stbQ.size() != 3) begin
         failures++; $display("[TB] FAIL bksp_count got=%0d exp=3", stbQ.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (stbQ[k] !== exp3[k]) begin failures++; $display("[TB] FAIL bksp_word%0d got=%h exp=%h", k, stbQ[k], exp3[k]); end
         end
      end
      checks++; if (cur_row !== 1'b0 || cur_col !== 4'd4) begin
         failures++; $display("[TB] FAIL bksp_cursor got=(%0d,%0d) exp=(0,4)", cur_row, cur_col); end
   endtask
`endif

   task automatic test_random();
      int pos, oldCol;
      logic [4:0] mask;
      logic [7:0] code;
      logic [8:0] exp[$];
      applyStimulus(5'b00010, 8'h00);
      waitIdle(500);
      pos = 0;
      for (int it = 0; it < 40; it++) begin
         mask = 5'($urandom_range(1, MASK_MAX));
         code = 8'($urandom);
         exp.delete();
         if (mask[0]) begin
            oldCol = pos % COLS;
            exp.push_back({1'b1, code});
            pos = (pos + 1) % NPOS;
            if (oldCol == COLS - 1) exp.push_back({1'b0, mvCmd(pos)});
         end else if (mask[1]) begin
            exp.push_back(9'h001);
            pos = 0;
         end else if (mask[4]) begin
            pos = (pos + NPOS - 1) % NPOS;
            exp.push_back({1'b0, mvCmd(pos)});
            exp.push_back(9'h120);
            exp.push_back({1'b0, mvCmd(pos)});
         end else if (mask[2]) begin
            pos = (pos + NPOS - 1) % NPOS;
            exp.push_back({1'b0, mvCmd(pos)});
         end else begin
            pos = (pos + 1) % NPOS;
            exp.push_back({1'b0, mvCmd(pos)});
         end
         stbQ.delete(); stbCyc.delete();
         applyStimulus(mask, code);
         waitIdle(500);
         checks++;
         if (stbQ.size() != exp.size()) begin
            failures++; $display("[TB] FAIL rand%0d_count mask=%b got=%0d exp=%0d", it, mask, stbQ.size(), exp.size());
         end else begin
            for (int k = 0; k < exp.size(); k++) begin
               checks++;
               if (stbQ[k] !== exp[k]) begin
                  failures++; $display("[TB] FAIL rand%0d_word%0d got=%h exp=%h", it, k, stbQ[k], exp[k]);
               end
            end
         end
         checks++;
         if (cur_row !== 1'(pos / COLS) || cur_col !== 4'(pos % COLS)) begin
            failures++; $display("[TB] FAIL rand%0d_cursor got=(%0d,%0d) exp=(%0d,%0d)", it, cur_row, cur_col, pos / COLS, pos % COLS);
         end
      end
   endtask

   task automatic test_reset_mid();
      int rel;
      stbQ.delete(); stbCyc.delete();
      applyStimulus(5'b00001, 8'h33);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (LCD_E !== 1'b0 || LCD_RS !== 1'b0 || LCD_RW !== 1'b0) begin
         failures++; $display("[TB] FAIL mid_ctrl got=E%b RS%b RW%b exp=000", LCD_E, LCD_RS, LCD_RW); end
      checks++; if (LCD_DATA !== 8'h00) begin failures++; $display("[TB] FAIL mid_data got=%h exp=00", LCD_DATA); end
      checks++; if (LED_out !== 8'h00 || busy !== 1'b1) begin
         failures++; $display("[TB] FAIL mid_led_busy got=%h/%b exp=00/1", LED_out, busy); end
      checks++; if (cur_row !== 1'b0 || cur_col !== 4'd0) begin
         failures++; $display("[TB] FAIL mid_cursor got=(%0d,%0d) exp=(0,0)", cur_row, cur_col); end
      repeat (15) @(negedge clk);
      checks++; if (stbQ.size() != 0) begin failures++; $display("[TB] FAIL mid_no_strobe got=%0d exp=0", stbQ.size()); end
      rel = cyc;
      rst = 1'b1;
      waitIdle(2000);
      checks++;
      if (stbQ.size() != 4) begin
         failures++; $display("[TB] FAIL replay_count got=%0d exp=4", stbQ.size());
      end else begin
         checks++; if (stbQ[0] !== 9'h038 || stbQ[3] !== 9'h001) begin
            failures++; $display("[TB] FAIL replay_words got=%h..%h exp=038..001", stbQ[0], stbQ[3]); end
         checks++; if (stbCyc[0] - rel != INIT_DLY + 1 + STROBE) begin
            failures++; $display("[TB] FAIL replay_first got=%0d exp=%0d", stbCyc[0] - rel, INIT_DLY + 1 + STROBE); end
      end
   endtask

   task automatic test_strobe_width();
      checks++;
      if (wideCount != 0) begin failures++; $display("[TB] FAIL strobe_width wide=%0d exp=0", wideCount); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_wrap();
      test_left_right();
      test_priority();
`ifdef LCD_BACKSPACE_EN
      test_bksp();
`endif
      test_random();
      test_reset_mid();
      test_strobe_width();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_cursor_multiline.md
LCD_CURSOR_MULTILINE -- requirements
Module: lcd_cursor_multiline

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ROWS, 2, display rows (1 or 2).
- COLS, 16, columns per row (1..40).
- INIT_DLY, 70, power-up wait cycles.
- CMD_DLY, 30, cycles per command or write state.
- CLR_DLY, 100, cycles for the clear command.
- STROBE, 20, cycle index in a state at which LCD_E pulses (STROBE < CMD_DLY).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-low.
- char_valid, in, 1, single-cycle pulse requesting a write of char_code.
- char_code, in, 8, ASCII character.
- left, in, 1, single-cycle pulse to move the cursor left.
- right, in, 1, single-cycle pulse to move the cursor right.
- clear, in, 1, single-cycle pulse to clear the display and home the cursor.
- LCD_E, out, 1, enable strobe.
- LCD_RS, out, 1, register select.
- LCD_RW, out, 1, read/write (always 0).
- LCD_DATA, out, 8, LCD bus.
- busy, out, 1, high when the controller is not in IDLE.
- cur_row, out, $clog2(ROWS) (min 1), cursor row.
- cur_col, out, $clog2(COLS), cursor column.
- LED_out, out, 8, one-hot state indicator.
REQ-003 Inputs arrive already one-shot (no internal edge detection).

Function
REQ-004 FSM states and fixed transitions:
- DELAY -> FUNC_SET -> DISP_ON -> ENTRY -> CLEAR -> IDLE.
- Each state dwells for its count and then advances: DELAY INIT_DLY, CLEAR CLR_DLY, all others CMD_DLY.
REQ-005 Bus words, held for the whole state:
- FUNC_SET: RS=0, 0x38.
- DISP_ON: RS=0, 0x0F.
- ENTRY: RS=0, 0x06.
- CLEAR: RS=0, 0x01.
- WRITE: RS=1, char.
- MOVE: RS=0, 0x80|addr.
- DELAY and IDLE: RS=0, 0x00.
REQ-006 LCD_E is high for exactly one cycle, at state-local count == STROBE, in every state except DELAY and IDLE.
REQ-007 Cursor addressing:
- DDRAM address = row_base + col, where row_base is 0x00 for row 0 and 0x40 for row 1.
- Every cursor move is issued as an explicit MOVE command.
REQ-008 IDLE event priority: char_valid > clear > left > right. Only the highest-priority event is accepted; the others in the same cycle are dropped.
REQ-009 Events arriving while busy=1 are dropped (no queue).
REQ-010 char_valid:
- Latch char_code on acceptance and enter WRITE.
- If col < COLS-1: col++ and return to IDLE.
- Otherwise col=0, row=(row+1) mod ROWS, then enter MOVE to realign the LCD address.
REQ-011 left:
- If col > 0: col--.
- Otherwise col=COLS-1, row=(row-1) mod ROWS; (0,0) wraps to (ROWS-1, COLS-1).
- Then MOVE.
REQ-012 right: mirror of left; (ROWS-1, COLS-1) wraps to (0,0); then MOVE.
REQ-013 clear: enter CLEAR with row=col=0.
REQ-014 cur_row and cur_col update on the cycle the event is accepted.
REQ-015 Unreachable state encodings recover to DELAY.
REQ-016 LED_out encoding: bit 7 DELAY, bit 6 FUNC_SET, bit 5 DISP_ON, bit 4 ENTRY, bit 3 CLEAR, bit 2 IDLE, bit 1 WRITE, bit 0 MOVE/BKSP.

Reset
REQ-017 While rst=0:
- state=DELAY, count=0, row=col=0.
- LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, LED_out=0x00, busy=1.
REQ-018 A reset asserted mid-command aborts the command immediately, with no partial strobe, and the full init sequence restarts on release.

Configuration
REQ-019 With LCD_BACKSPACE_EN defined:
- An input bksp (1 bit, single-cycle pulse) is added, with priority between clear and left.
- The accepted sequence is MOVE to the left position (wrap rules of REQ-011), WRITE 0x20, then MOVE back to that same left position.
- The final cursor is the left position.
REQ-020 Without LCD_BACKSPACE_EN, the bksp port and its states are absent.

Structure
REQ-021 Shared package lcd_pkg holds:
- The state enum.
- Command constants: 0x38, 0x0F, 0x06, 0x01, 0x80.
- ROW_BASE constants.
REQ-022 Sub-module lcd_addr_calc (combinational) computes the next row/col and the DDRAM address for the inc/dec/wrap cases.

Verification
REQ-023 The bench shall cover the following directed scenarios:
- Reset release: LCD_E strobes carry 0x38, 0x0F, 0x06, 0x01 in order, first strobe at cycle INIT_DLY+1+STROBE; busy falls after CLEAR.
- Write 'A' at (0,0): one strobe with RS=1, DATA=0x41; cur_col=1; busy for CMD_DLY+1 cycles.
- Sixteen writes with COLS=16, ROWS=2: the 16th is followed by a MOVE with DATA=0xC0, cursor (1,0); 32 writes wrap to 0x80, cursor (0,0).
- left at (0,0): MOVE with DATA=0xCF, cursor (1,15); right at (1,15): DATA=0x80.
- char_valid and left in the same cycle: only the write occurs; a right pulse during busy is ignored and the cursor is unchanged.
- Reset at WRITE count 10: no strobe, all outputs at reset values, init replays; with LCD_BACKSPACE_EN, bksp at (0,5) gives 0x84, 0x20, 0x84, cursor (0,4).
